// File: rtl/wb_stage_pkg.sv
// Shared widths, source selects, load funct3 codes and FSM state encoding for wb_stage.
package wb_stage_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int WB_SRC_WIDTH   = 1;

  localparam logic [WB_SRC_WIDTH-1:0] WB_SRC_ALU = 1'b0;
  localparam logic [WB_SRC_WIDTH-1:0] WB_SRC_MEM = 1'b1;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// load_ext: picks the byte/half lane of a load response and sign- or zero-extends it.
module load_ext
  import wb_stage_pkg::*;
(
  input  logic [CPU_WIDTH-1:0] mem_rsp_data,
  input  logic [1:0]           addr_lo,
  input  logic [2:0]           load_type,
  output logic [CPU_WIDTH-1:0] ext_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = mem_rsp_data[7:0];
    case (addr_lo)
      2'd0: lane_byte = mem_rsp_data[7:0];
      2'd1: lane_byte = mem_rsp_data[15:8];
      2'd2: lane_byte = mem_rsp_data[23:16];
      2'd3: lane_byte = mem_rsp_data[31:24];
      default: lane_byte = mem_rsp_data[7:0];
    endcase
    lane_half = addr_lo[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
  end

  // Unlisted funct3 codes fall through to a full-word load.
  always_comb begin
    ext_data = mem_rsp_data;
    case (load_type)
      LOAD_LB:  ext_data = {{24{lane_byte[7]}}, lane_byte};
      LOAD_LBU: ext_data = {24'd0, lane_byte};
      LOAD_LH:  ext_data = {{16{lane_half[15]}}, lane_half};
      LOAD_LHU: ext_data = {16'd0, lane_half};
      default:  ext_data = mem_rsp_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU or extended load results onto the register-file write port.
// Optional WB_HAZARD_EN exposes the pending load destination on hz_vld/hz_addr.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_vld,
  output logic                      ex_rdy,
  input  logic [WB_SRC_WIDTH-1:0]   ex_wb_src,
  input  logic                      ex_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr,
  input  logic [CPU_WIDTH-1:0]      ex_alu_res,
  input  logic [1:0]                ex_addr_lo,
  input  logic [2:0]                ex_load_type,
  input  logic                      mem_rsp_vld,
  input  logic [CPU_WIDTH-1:0]      mem_rsp_data,
  input  logic                      mem_rsp_err,
  output logic                      reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [CPU_WIDTH-1:0]      reg_wdata,
  output logic                      load_err,
  output logic                      hz_vld,
  output logic [REG_ADDR_WIDTH-1:0] hz_addr
);

  wb_state_t                 state_reg;
  logic                      ex_rdy_reg;
  logic                      reg_wen_reg;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr_reg;
  logic [CPU_WIDTH-1:0]      reg_wdata_reg;
  logic                      load_err_reg;
  logic                      pend_wen_reg;
  logic [REG_ADDR_WIDTH-1:0] pend_waddr_reg;
  logic [1:0]                pend_addr_lo_reg;
  logic [2:0]                pend_load_type_reg;

  logic                      accept;
  logic                      load_accept;
  logic                      rsp_done;
  logic                      ex_writes_rd;
  logic [CPU_WIDTH-1:0]      load_data;

  assign accept       = (state_reg == WB_IDLE) && ex_vld && ex_rdy_reg;
  assign load_accept  = accept && (ex_wb_src == WB_SRC_MEM);
  assign rsp_done     = (state_reg == WB_WAIT_MEM) && mem_rsp_vld;
  assign ex_writes_rd = ex_reg_wen && (ex_reg_waddr != '0);

  load_ext u_load_ext (
    .mem_rsp_data (mem_rsp_data),
    .addr_lo      (pend_addr_lo_reg),
    .load_type    (pend_load_type_reg),
    .ext_data     (load_data)
  );

  // ex_rdy comes out of reset low and rises on the first clock in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= WB_IDLE;
      ex_rdy_reg         <= 1'b0;
      reg_wen_reg        <= 1'b0;
      reg_waddr_reg      <= '0;
      reg_wdata_reg      <= '0;
      load_err_reg       <= 1'b0;
      pend_wen_reg       <= 1'b0;
      pend_waddr_reg     <= '0;
      pend_addr_lo_reg   <= '0;
      pend_load_type_reg <= '0;
    end else begin
      reg_wen_reg  <= 1'b0;
      load_err_reg <= 1'b0;
      case (state_reg)
        WB_IDLE: begin
          ex_rdy_reg <= 1'b1;
          if (load_accept) begin
            state_reg          <= WB_WAIT_MEM;
            ex_rdy_reg         <= 1'b0;
            pend_wen_reg       <= ex_writes_rd;
            pend_waddr_reg     <= ex_reg_waddr;
            pend_addr_lo_reg   <= ex_addr_lo;
            pend_load_type_reg <= ex_load_type;
          end else if (accept && ex_writes_rd) begin
            reg_wen_reg   <= 1'b1;
            reg_waddr_reg <= ex_reg_waddr;
            reg_wdata_reg <= ex_alu_res;
          end
        end
        WB_WAIT_MEM: begin
          if (rsp_done) begin
            state_reg  <= WB_IDLE;
            ex_rdy_reg <= 1'b1;
            if (mem_rsp_err) begin
              load_err_reg <= 1'b1;
            end else if (pend_wen_reg) begin
              reg_wen_reg   <= 1'b1;
              reg_waddr_reg <= pend_waddr_reg;
              reg_wdata_reg <= load_data;
            end
          end
        end
        default: state_reg <= WB_IDLE;
      endcase
    end
  end

`ifdef WB_HAZARD_EN
  logic                      hz_vld_reg;
  logic [REG_ADDR_WIDTH-1:0] hz_addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_vld_reg  <= 1'b0;
      hz_addr_reg <= '0;
    end else if (load_accept) begin
      hz_vld_reg  <= ex_writes_rd;
      hz_addr_reg <= ex_writes_rd ? ex_reg_waddr : '0;
    end else if (rsp_done) begin
      hz_vld_reg  <= 1'b0;
      hz_addr_reg <= '0;
    end
  end

  assign hz_vld  = hz_vld_reg;
  assign hz_addr = hz_addr_reg;
`else
  assign hz_vld  = 1'b0;
  assign hz_addr = '0;
`endif

  assign ex_rdy    = ex_rdy_reg;
  assign reg_wen   = reg_wen_reg;
  assign reg_waddr = reg_waddr_reg;
  assign reg_wdata = reg_wdata_reg;
  assign load_err  = load_err_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU writes, load extension, errors, strays and mid-load reset.
module tb_wb_stage;
  import wb_stage_pkg::*;

`ifdef WB_HAZARD_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic                      clk;
  logic                      rst_n;
  logic                      ex_vld;
  logic                      ex_rdy;
  logic [WB_SRC_WIDTH-1:0]   ex_wb_src;
  logic                      ex_reg_wen;
  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr;
  logic [CPU_WIDTH-1:0]      ex_alu_res;
  logic [1:0]                ex_addr_lo;
  logic [2:0]                ex_load_type;
  logic                      mem_rsp_vld;
  logic [CPU_WIDTH-1:0]      mem_rsp_data;
  logic                      mem_rsp_err;
  logic                      reg_wen;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr;
  logic [CPU_WIDTH-1:0]      reg_wdata;
  logic                      load_err;
  logic                      hz_vld;
  logic [REG_ADDR_WIDTH-1:0] hz_addr;

  int checks;
  int errors;

  wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_vld       (ex_vld),
    .ex_rdy       (ex_rdy),
    .ex_wb_src    (ex_wb_src),
    .ex_reg_wen   (ex_reg_wen),
    .ex_reg_waddr (ex_reg_waddr),
    .ex_alu_res   (ex_alu_res),
    .ex_addr_lo   (ex_addr_lo),
    .ex_load_type (ex_load_type),
    .mem_rsp_vld  (mem_rsp_vld),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_err  (mem_rsp_err),
    .reg_wen      (reg_wen),
    .reg_waddr    (reg_waddr),
    .reg_wdata    (reg_wdata),
    .load_err     (load_err),
    .hz_vld       (hz_vld),
    .hz_addr      (hz_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic wen, input logic [31:0] res);
    ex_vld       = 1'b1;
    ex_wb_src    = WB_SRC_ALU;
    ex_reg_wen   = wen;
    ex_reg_waddr = rd;
    ex_alu_res   = res;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic wen, input logic [1:0] lo,
                            input logic [2:0] ltype);
    ex_vld       = 1'b1;
    ex_wb_src    = WB_SRC_MEM;
    ex_reg_wen   = wen;
    ex_reg_waddr = rd;
    ex_addr_lo   = lo;
    ex_load_type = ltype;
    ex_alu_res   = 32'hDEAD_BEEF;
  endtask

  task automatic alu_op(input string tag, input logic [4:0] rd, input logic wen,
                        input logic [31:0] res, input logic exp_wen);
    drive_alu(rd, wen, res);
    tick();
    ex_vld = 1'b0;
    check({tag, " wen"}, {31'd0, reg_wen}, {31'd0, exp_wen});
    if (exp_wen) begin
      check({tag, " waddr"}, {27'd0, reg_waddr}, {27'd0, rd});
      check({tag, " wdata"}, reg_wdata, res);
    end
    tick();
    check({tag, " wen drop"}, {31'd0, reg_wen}, 32'd0);
  endtask

  // Load accepted, response after `gap` idle wait cycles, then check the write or error.
  task automatic load_op(input string tag, input logic [4:0] rd, input logic wen,
                         input logic [1:0] lo, input logic [2:0] ltype, input int gap,
                         input logic [31:0] data, input logic err, input logic [31:0] exp_data);
    logic exp_wen;
    logic exp_hz;
    exp_wen = wen && (rd != 5'd0) && !err;
    exp_hz  = HZ_EN && wen && (rd != 5'd0);
    drive_load(rd, wen, lo, ltype);
    tick();
    ex_vld = 1'b0;
    check({tag, " rdy wait"}, {31'd0, ex_rdy}, 32'd0);
    check({tag, " hz_vld"}, {31'd0, hz_vld}, {31'd0, exp_hz});
    check({tag, " hz_addr"}, {27'd0, hz_addr}, exp_hz ? {27'd0, rd} : 32'd0);
    for (int i = 0; i < gap; i++) begin
      tick();
      check({tag, " rdy hold"}, {31'd0, ex_rdy}, 32'd0);
    end
    mem_rsp_vld  = 1'b1;
    mem_rsp_data = data;
    mem_rsp_err  = err;
    tick();
    mem_rsp_vld = 1'b0;
    mem_rsp_err = 1'b0;
    check({tag, " wen"}, {31'd0, reg_wen}, {31'd0, exp_wen});
    check({tag, " load_err"}, {31'd0, load_err}, {31'd0, err});
    check({tag, " rdy back"}, {31'd0, ex_rdy}, 32'd1);
    check({tag, " hz clear"}, {31'd0, hz_vld}, 32'd0);
    if (exp_wen) begin
      check({tag, " waddr"}, {27'd0, reg_waddr}, {27'd0, rd});
      check({tag, " wdata"}, reg_wdata, exp_data);
    end
    tick();
    check({tag, " wen drop"}, {31'd0, reg_wen}, 32'd0);
    check({tag, " err drop"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    ex_vld       = 1'b0;
    ex_wb_src    = WB_SRC_ALU;
    ex_reg_wen   = 1'b0;
    ex_reg_waddr = '0;
    ex_alu_res   = '0;
    ex_addr_lo   = '0;
    ex_load_type = '0;
    mem_rsp_vld  = 1'b0;
    mem_rsp_data = '0;
    mem_rsp_err  = 1'b0;

    repeat (2) tick();
    check("rst ex_rdy", {31'd0, ex_rdy}, 32'd0);
    check("rst reg_wen", {31'd0, reg_wen}, 32'd0);
    check("rst reg_waddr", {27'd0, reg_waddr}, 32'd0);
    check("rst reg_wdata", reg_wdata, 32'd0);
    check("rst load_err", {31'd0, load_err}, 32'd0);
    check("rst hz_vld", {31'd0, hz_vld}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle ex_rdy", {31'd0, ex_rdy}, 32'd1);

    alu_op("alu rd5", 5'd5, 1'b1, 32'h1234_5678, 1'b1);

    // Back-to-back ALU ops: one write per cycle.
    drive_alu(5'd1, 1'b1, 32'h0000_0011);
    tick();
    check("b2b0 wdata", reg_wdata, 32'h0000_0011);
    drive_alu(5'd2, 1'b1, 32'h0000_0022);
    tick();
    ex_vld = 1'b0;
    check("b2b1 wen", {31'd0, reg_wen}, 32'd1);
    check("b2b1 waddr", {27'd0, reg_waddr}, 32'd2);
    check("b2b1 wdata", reg_wdata, 32'h0000_0022);
    tick();
    check("b2b wen drop", {31'd0, reg_wen}, 32'd0);
    check("hold waddr", {27'd0, reg_waddr}, 32'd2);
    check("hold wdata", reg_wdata, 32'h0000_0022);

    load_op("lb",   5'd3, 1'b1, 2'd2, LOAD_LB,  1, 32'h0080_0000, 1'b0, 32'hFFFF_FF80);
    load_op("lhu",  5'd7, 1'b1, 2'd2, LOAD_LHU, 0, 32'hBEEF_0000, 1'b0, 32'h0000_BEEF);
    load_op("lh",   5'd7, 1'b1, 2'd2, LOAD_LH,  0, 32'hBEEF_0000, 1'b0, 32'hFFFF_BEEF);
    load_op("lw",   5'd8, 1'b1, 2'd3, LOAD_LW,  2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D);
    load_op("lbu",  5'd4, 1'b1, 2'd1, LOAD_LBU, 0, 32'h0000_9A00, 1'b0, 32'h0000_009A);
    load_op("lh lo", 5'd6, 1'b1, 2'd0, LOAD_LH, 0, 32'h1234_8001, 1'b0, 32'hFFFF_8001);
    load_op("f3 011", 5'd10, 1'b1, 2'd1, 3'b011, 0, 32'h8765_4321, 1'b0, 32'h8765_4321);
    load_op("ld rd0", 5'd0, 1'b1, 2'd0, LOAD_LW, 1, 32'h5555_5555, 1'b0, 32'h0);
    load_op("ld nowen", 5'd12, 1'b0, 2'd0, LOAD_LW, 0, 32'h6666_6666, 1'b0, 32'h0);
    load_op("ld err", 5'd9, 1'b1, 2'd0, LOAD_LW, 1, 32'h7777_7777, 1'b1, 32'h0);

    alu_op("alu rd0", 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    alu_op("alu nowen", 5'd11, 1'b0, 32'hABCD_0000, 1'b0);

    // Stray response while idle.
    mem_rsp_vld  = 1'b1;
    mem_rsp_data = 32'h1111_2222;
    tick();
    mem_rsp_vld = 1'b0;
    check("stray wen", {31'd0, reg_wen}, 32'd0);
    check("stray err", {31'd0, load_err}, 32'd0);
    check("stray rdy", {31'd0, ex_rdy}, 32'd1);

    // Next op accepted while the load write is on the port.
    drive_load(5'd13, 1'b1, 2'd0, LOAD_LW);
    tick();
    ex_vld       = 1'b0;
    mem_rsp_vld  = 1'b1;
    mem_rsp_data = 32'h0BAD_F00D;
    tick();
    mem_rsp_vld = 1'b0;
    check("ovl ld wdata", reg_wdata, 32'h0BAD_F00D);
    check("ovl rdy", {31'd0, ex_rdy}, 32'd1);
    drive_alu(5'd14, 1'b1, 32'h0000_0E0E);
    tick();
    ex_vld = 1'b0;
    check("ovl alu wen", {31'd0, reg_wen}, 32'd1);
    check("ovl alu waddr", {27'd0, reg_waddr}, 32'd14);
    check("ovl alu wdata", reg_wdata, 32'h0000_0E0E);
    tick();

    // Reset during WAIT_MEM; the late response must be treated as stray.
    drive_load(5'd15, 1'b1, 2'd0, LOAD_LW);
    tick();
    ex_vld = 1'b0;
    check("mid rdy wait", {31'd0, ex_rdy}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid rst rdy", {31'd0, ex_rdy}, 32'd0);
    check("mid rst hz", {31'd0, hz_vld}, 32'd0);
    check("mid rst wdata", reg_wdata, 32'd0);
    check("mid rst waddr", {27'd0, reg_waddr}, 32'd0);
    tick();
    rst_n        = 1'b1;
    mem_rsp_vld  = 1'b1;
    mem_rsp_data = 32'h9999_9999;
    tick();
    mem_rsp_vld = 1'b0;
    check("post rst wen", {31'd0, reg_wen}, 32'd0);
    check("post rst err", {31'd0, load_err}, 32'd0);
    check("post rst wdata", reg_wdata, 32'd0);
    check("post rst rdy", {31'd0, ex_rdy}, 32'd1);
    alu_op("post rst alu", 5'd16, 1'b1, 32'h0F0F_0F0F, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
